// File: rtl/upsampler_variable_pkg.sv
// rtl/upsampler_variable_pkg.sv - shared types and constants for the variable-rate upsampler
package upsampler_variable_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int RATE_MIN = 1;

endpackage

// File: rtl/upsampler_variable_if.sv
// rtl/upsampler_variable_if.sv - sample, rate and output stream bundle for the upsampler
interface upsampler_variable_if
    import upsampler_variable_pkg::*;
#(
    parameter int DATA_WIDTH_INP  = 8,
    parameter int DATA_WIDTH_RATE = 16
);
    logic [DATA_WIDTH_INP-1:0]  s_axis_in_tdata;
    logic                       s_axis_in_tvalid;
    logic                       s_axis_in_tready;
    logic [DATA_WIDTH_RATE-1:0] s_axis_rate_tdata;
    logic                       s_axis_rate_tvalid;
    logic [DATA_WIDTH_INP-1:0]  m_axis_out_tdata;
    logic                       m_axis_out_tvalid;
    logic                       m_axis_out_tready;

    modport master (
        output s_axis_in_tdata, s_axis_in_tvalid, s_axis_rate_tdata, s_axis_rate_tvalid,
        output m_axis_out_tready,
        input  s_axis_in_tready, m_axis_out_tdata, m_axis_out_tvalid
    );

    modport slave (
        input  s_axis_in_tdata, s_axis_in_tvalid, s_axis_rate_tdata, s_axis_rate_tvalid,
        input  m_axis_out_tready,
        output s_axis_in_tready, m_axis_out_tdata, m_axis_out_tvalid
    );
endinterface

// File: rtl/upsampler_variable.sv
// rtl/upsampler_variable.sv - emits R beats per input sample, zero-stuffed or held
module upsampler_variable
    import upsampler_variable_pkg::*;
#(
    parameter int DATA_WIDTH_INP  = 8,
    parameter int DATA_WIDTH_RATE = 16,
    parameter int HOLD            = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [DATA_WIDTH_INP-1:0]  s_axis_in_tdata,
    input  logic                       s_axis_in_tvalid,
    output logic                       s_axis_in_tready,
    input  logic [DATA_WIDTH_RATE-1:0] s_axis_rate_tdata,
    input  logic                       s_axis_rate_tvalid,
    output logic [DATA_WIDTH_INP-1:0]  m_axis_out_tdata,
    output logic                       m_axis_out_tvalid,
    input  logic                       m_axis_out_tready
);

    localparam logic [DATA_WIDTH_RATE-1:0] RATE_ONE = DATA_WIDTH_RATE'(RATE_MIN);

    state_t                     state_q;
    logic [DATA_WIDTH_RATE-1:0] rate_buf_q;
    logic [DATA_WIDTH_RATE-1:0] phase_q;
    logic [DATA_WIDTH_INP-1:0]  sample_q;
    logic [DATA_WIDTH_INP-1:0]  data_q;
    logic                       valid_q;

    logic [DATA_WIDTH_RATE-1:0] rate_d;
    logic                       last_beat;
    logic                       in_hs;
    logic                       out_hs;

    // rate_buf_q is never zero, so rate_buf_q-1 is always a valid last phase
    always_comb begin
        rate_d           = (s_axis_rate_tdata == '0) ? RATE_ONE : s_axis_rate_tdata;
        last_beat        = (phase_q == (rate_buf_q - RATE_ONE));
        out_hs           = valid_q && m_axis_out_tready;
        s_axis_in_tready = reset_n && !s_axis_rate_tvalid &&
                           (!valid_q || (m_axis_out_tready && last_beat));
        in_hs            = s_axis_in_tvalid && s_axis_in_tready;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rate_buf_q <= RATE_ONE;
            phase_q    <= '0;
            sample_q   <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
        end else if (s_axis_rate_tvalid) begin
            rate_buf_q <= rate_d;
            state_q    <= IDLE;
            phase_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
        end else if (in_hs) begin
            // also covers the back-to-back case where beat R-1 retires this cycle
            state_q  <= EMIT;
            sample_q <= s_axis_in_tdata;
            data_q   <= s_axis_in_tdata;
            valid_q  <= 1'b1;
            phase_q  <= '0;
        end else if (out_hs) begin
            if (last_beat) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                phase_q <= '0;
            end else begin
                phase_q <= phase_q + RATE_ONE;
                data_q  <= (HOLD != 0) ? sample_q : '0;
            end
        end
    end

    assign m_axis_out_tdata  = data_q;
    assign m_axis_out_tvalid = valid_q;

endmodule
